if_fetch_queue: RTL

IF_FETCH_QUEUE -- requirements
Module: if_fetch_queue

---
 rtl/fetch_pkg.sv | 9 +
 rtl/fetch_ring.sv | 40 ++++
 rtl/if_fetch_queue.sv | 62 ++++++
 3 files changed

// File: rtl/fetch_pkg.sv
// fetch_pkg: shared constants and queue-entry type for the instruction fetch queue
package fetch_pkg;
  localparam int XLEN_DEFAULT = 32;
  localparam int PC_STEP = 4;
  typedef struct packed {
    logic [XLEN_DEFAULT-1:0] inst;
    logic [XLEN_DEFAULT-1:0] pc_plus;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_ring.sv
// fetch_ring: DEPTH-entry ring buffer (storage, head/tail pointers, occupancy); ports: clk, rst (sync active-low), flush_i, wr_en_i/wr_data_i, rd_en_i/rd_data_o, count_o
module fetch_ring #(
  parameter int W = 64,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush_i,
  input  logic                       wr_en_i,
  input  logic [W-1:0]               wr_data_i,
  input  logic                       rd_en_i,
  output logic [W-1:0]               rd_data_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  logic [W-1:0] mem_q [DEPTH];
  logic [AW-1:0] head_q, tail_q, head_d, tail_d;
  logic [CW-1:0] count_q, count_d;
  // pointers wrap for free because DEPTH is a power of two
  always_comb begin
    head_d = rd_en_i ? head_q + 1'b1 : head_q;
    tail_d = wr_en_i ? tail_q + 1'b1 : tail_q;
    count_d = count_q + CW'(wr_en_i) - CW'(rd_en_i);
  end
  always_ff @(posedge clk) begin
    if (!rst || flush_i) begin
      head_q <= '0;
      tail_q <= '0;
      count_q <= '0;
    end else begin
      if (wr_en_i) mem_q[tail_q] <= wr_data_i;
      head_q <= head_d;
      tail_q <= tail_d;
      count_q <= count_d;
    end
  end
  assign rd_data_o = mem_q[head_q];
  assign count_o = count_q;
endmodule

// File: rtl/if_fetch_queue.sv
// if_fetch_queue: PC generation, fetch request and redirect handling in front of a fetch_ring; ports: clk, rst (sync active-low), imem_req/imem_addr/imem_gnt/imem_rdata, redirect_valid/redirect_pc, deq_valid/deq_ready/deq_inst/deq_pc_plus, count; IF_FETCH_BYPASS_EN enables same-cycle empty-queue bypass
module if_fetch_queue
  import fetch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT,
  parameter int DEPTH = 4,
  parameter logic [XLEN-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  output logic                       imem_req,
  output logic [XLEN-1:0]            imem_addr,
  input  logic                       imem_gnt,
  input  logic [XLEN-1:0]            imem_rdata,
  input  logic                       redirect_valid,
  input  logic [XLEN-1:0]            redirect_pc,
  output logic                       deq_valid,
  input  logic                       deq_ready,
  output logic [XLEN-1:0]            deq_inst,
  output logic [XLEN-1:0]            deq_pc_plus,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int CW = $clog2(DEPTH+1);
  logic [XLEN-1:0] pc_q, pc_d, pc_plus;
  logic [2*XLEN-1:0] head;
  logic head_ok, enq, wr, rd, empty;
  assign pc_plus = pc_q + XLEN'(PC_STEP);
  assign empty = count == '0;
  // head_ok excludes the bypass path so imem_req has no combinational loop through deq_valid
  assign head_ok = rst & ~redirect_valid & ~empty;
  assign imem_req = rst & ~redirect_valid & ((count < CW'(DEPTH)) | (head_ok & deq_ready));
  assign enq = imem_req & imem_gnt;
  assign rd = head_ok & deq_ready;
`ifdef IF_FETCH_BYPASS_EN
  logic byp;
  assign byp = empty & enq;
  assign deq_valid = head_ok | byp;
  assign {deq_inst, deq_pc_plus} = byp ? {imem_rdata, pc_plus} : head;
  // a bypassed entry consumed the same cycle never lands in the ring
  assign wr = enq & ~(byp & deq_ready);
`else
  assign deq_valid = head_ok;
  assign {deq_inst, deq_pc_plus} = head;
  assign wr = enq;
`endif
  always_comb pc_d = redirect_valid ? (redirect_pc & ~XLEN'(3)) : enq ? pc_plus : pc_q;
  always_ff @(posedge clk) begin
    if (!rst) pc_q <= RESET_PC;
    else pc_q <= pc_d;
  end
  assign imem_addr = pc_q;
  fetch_ring #(.W(2*XLEN), .DEPTH(DEPTH)) u_ring (
    .clk(clk),
    .rst(rst),
    .flush_i(redirect_valid),
    .wr_en_i(wr),
    .wr_data_i({imem_rdata, pc_plus}),
    .rd_en_i(rd),
    .rd_data_o(head),
    .count_o(count)
  );
endmodule
